demux1to32: RTL and testbench

DEMUX1TO32 -- requirements
Module: demux1to32

---
 rtl/demux_pkg.sv | 8 +
 rtl/demux_lane.sv | 43 ++++
 rtl/demux1to32.sv | 65 ++++++
 tb/tb_demux1to32.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-N registered demultiplexer.
package demux_pkg;
    localparam int WIDTH_DEF = 8;
    localparam int LANES_DEF = 32;
    localparam int CNT_W     = 16;

    typedef logic [WIDTH_DEF-1:0] lane_t;
endpackage

// File: rtl/demux_lane.sv
// One-entry output buffer. A load and a drain in the same cycle keep the lane
// full and hold the new beat.
module demux_lane
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);
    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (full_q && out_ready) begin
            full_d = 1'b0;
        end
        if (load) begin
            full_d = 1'b1;
            data_d = load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign out_valid = full_q;
    assign out_data  = data_q;
endmodule

// File: rtl/demux1to32.sv
// Registered 1-to-LANES demultiplexer: select decode, ready mux and accept
// counter at the top, one single-entry buffer per lane.
module demux1to32
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LANES = LANES_DEF,
    localparam int SEL_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH-1:0]            in_data,
    input  logic [SEL_W-1:0]            in_sel,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [LANES-1:0][WIDTH-1:0] out_data,
    output logic [LANES-1:0]            out_valid,
    input  logic [LANES-1:0]            out_ready,
    output logic [CNT_W-1:0]            acc_cnt
);
    localparam logic [SEL_W:0] LANE_LIM = (SEL_W+1)'(LANES);

    logic             sel_ok;
    logic             accept;
    logic [LANES-1:0] load_vec;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;

    // Out-of-range selects (non power-of-two LANES) are never accepted.
    assign sel_ok   = {1'b0, in_sel} < LANE_LIM;
    assign in_ready = !rst && sel_ok && (!out_valid[in_sel] || out_ready[in_sel]);
    assign accept   = in_valid && in_ready;

    always_comb begin
        load_vec = '0;
        if (accept) begin
            load_vec[in_sel] = 1'b1;
        end
    end

    always_comb begin
        acc_cnt_d = acc_cnt_q + CNT_W'(accept);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt_q <= '0;
        end else begin
            acc_cnt_q <= acc_cnt_d;
        end
    end

    assign acc_cnt = acc_cnt_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        demux_lane #(.WIDTH(WIDTH)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .load      (load_vec[k]),
            .load_data (in_data),
            .out_ready (out_ready[k]),
            .out_valid (out_valid[k]),
            .out_data  (out_data[k])
        );
    end
endmodule

// File: tb/tb_demux1to32.sv
// Directed and randomized checks of demux1to32 against a lane-array model.
module tb_demux1to32;
    import demux_pkg::*;

    localparam int W = 8;
    localparam int L = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic [W-1:0]        in_data;
    logic [4:0]          in_sel;
    logic                in_valid;
    logic                in_ready;
    logic [L-1:0][W-1:0] out_data;
    logic [L-1:0]        out_valid;
    logic [L-1:0]        out_ready;
    logic [15:0]         acc_cnt;

    demux1to32 #(.WIDTH(W), .LANES(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_cnt   (acc_cnt)
    );

    always #5 clk = ~clk;

    // Model: per-lane occupancy and contents plus a beat counter.
    bit          m_full [L];
    lane_t       m_data [L];
    logic [15:0] m_cnt;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Compare DUT to model mid-cycle, then advance the model across the edge.
    task automatic step();
        logic [L-1:0]   ev;
        logic [255:0]   ed;
        logic           er;
        @(negedge clk);
        ed = '0;
        for (int k = 0; k < L; k++) begin
            ev[k] = m_full[k];
            ed[k*W +: W] = m_data[k];
        end
        er = !rst && (!m_full[in_sel] || out_ready[in_sel]);
        chk("in_ready", 256'(in_ready), 256'(er));
        chk("out_valid", 256'(out_valid), 256'(ev));
        chk("out_data", out_data, ed);
        chk("acc_cnt", 256'(acc_cnt), 256'(m_cnt));
        if (rst) begin
            for (int k = 0; k < L; k++) begin
                m_full[k] = 1'b0;
                m_data[k] = '0;
            end
            m_cnt = '0;
        end else begin
            for (int k = 0; k < L; k++)
                if (m_full[k] && out_ready[k]) m_full[k] = 1'b0;
            if (in_valid && er) begin
                m_full[in_sel] = 1'b1;
                m_data[in_sel] = in_data;
                m_cnt = m_cnt + 16'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [4:0] s, input logic [W-1:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        #1;
    endtask

    initial begin
        for (int k = 0; k < L; k++) begin
            m_full[k] = 1'b0;
            m_data[k] = '0;
        end
        m_cnt     = '0;
        rst       = 1'b1;
        out_ready = '0;
        drive(1'b1, 5'd3, 8'h55);
        chk("in_ready_in_reset", 256'(in_ready), 256'(0));
        step();
        step();
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_out_data", out_data, 256'(0));
        chk("rst_acc_cnt", 256'(acc_cnt), 256'(0));
        rst = 1'b0;

        // Basic routing
        drive(1'b1, 5'd5, 8'hA5);
        step();
        drive(1'b0, 5'd0, 8'h00);
        chk("route_valid", 256'(out_valid), 256'(32'h0000_0020));
        chk("route_data5", 256'(out_data[5]), 256'(8'hA5));
        chk("route_cnt", 256'(acc_cnt), 256'(1));

        // Backpressure
        drive(1'b1, 5'd5, 8'h3C);
        chk("bp_in_ready", 256'(in_ready), 256'(0));
        step();
        chk("bp_data5", 256'(out_data[5]), 256'(8'hA5));
        chk("bp_cnt", 256'(acc_cnt), 256'(1));

        // Pass-through: drain and reload in the same cycle
        out_ready[5] = 1'b1;
        drive(1'b1, 5'd5, 8'h3C);
        chk("pt_in_ready", 256'(in_ready), 256'(1));
        step();
        out_ready = '0;
        drive(1'b0, 5'd0, 8'h00);
        chk("pt_data5", 256'(out_data[5]), 256'(8'h3C));
        chk("pt_valid5", 256'(out_valid[5]), 256'(1));
        chk("pt_cnt", 256'(acc_cnt), 256'(2));

        // Non-blocking around a stalled lane
        drive(1'b1, 5'd31, 8'h11);
        chk("nb_ready31", 256'(in_ready), 256'(1));
        step();
        drive(1'b1, 5'd0, 8'h22);
        chk("nb_ready0", 256'(in_ready), 256'(1));
        step();
        drive(1'b0, 5'd0, 8'h00);
        chk("nb_valid", 256'(out_valid), 256'(32'h8000_0021));
        chk("nb_data5", 256'(out_data[5]), 256'(8'h3C));
        chk("nb_data31", 256'(out_data[31]), 256'(8'h11));
        chk("nb_data0", 256'(out_data[0]), 256'(8'h22));
        chk("nb_cnt", 256'(acc_cnt), 256'(4));

        // Reset mid-operation with lanes 0, 5, 31 full
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", 256'(out_valid), 256'(0));
        chk("mid_rst_cnt", 256'(acc_cnt), 256'(0));
        drive(1'b1, 5'd7, 8'h77);
        chk("post_rst_ready", 256'(in_ready), 256'(1));
        step();
        drive(1'b0, 5'd0, 8'h00);
        chk("post_rst_valid", 256'(out_valid), 256'(32'h0000_0080));
        chk("post_rst_data7", 256'(out_data[7]), 256'(8'h77));
        chk("post_rst_cnt", 256'(acc_cnt), 256'(1));

        // Randomized traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            out_ready = $urandom() & $urandom();
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, L-1)), 8'($urandom()));
            step();
        end

        // Counter wrap: every lane drains each cycle so every beat is accepted
        rst = 1'b1;
        drive(1'b0, 5'd0, 8'h00);
        step();
        rst       = 1'b0;
        out_ready = '1;
        for (int i = 0; i < 65535; i++) begin
            drive(1'b1, 5'($urandom_range(0, L-1)), 8'($urandom()));
            step();
        end
        chk("wrap_pre", 256'(acc_cnt), 256'(16'hFFFF));
        drive(1'b1, 5'd9, 8'h99);
        step();
        drive(1'b0, 5'd0, 8'h00);
        chk("wrap_post", 256'(acc_cnt), 256'(16'h0000));
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
